memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_pkg.sv | 15 +
 rtl/bus_timeout_counter.sv | 28 ++
 rtl/memory_arbiter.sv | 109 ++++++++++
 tb/tb_memory_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package memory_arbiter_pkg;

  localparam int unsigned DATA_W           = 32;
  localparam int unsigned CNT_W            = 8;
  localparam int unsigned TIMEOUT_DEFAULT  = 16;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_IF  = 2'd1,
    GRANT_MEM = 2'd2
  } arb_state_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Per-grant wait counter; flags the last cycle a grant may wait for ready.
module bus_timeout_counter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc_c = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/memory_arbiter.sv
// Fixed-priority arbiter sharing one memory bus between a fetch port and a
// data port, with a per-grant timeout that aborts stuck accesses.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned        TIMEOUT  = TIMEOUT_DEFAULT,
  parameter logic [DATA_W-1:0]  ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_if_req,
  input  logic [DATA_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_done,
  output logic              o_if_stall,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [DATA_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_mem_done,
  output logic              o_mem_stall,
  output logic              o_err,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [DATA_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic              i_bus_ready,
  input  logic [DATA_W-1:0] i_bus_rdata
);

  arb_state_t state;
  logic       tc_c;
  logic       mem_elig_c;
  logic       if_elig_c;
  logic       granted_c;

  // A port that is showing done this cycle is not re-granted on its held request.
  assign mem_elig_c = i_mem_req & ~o_mem_done;
  assign if_elig_c  = i_if_req  & ~o_if_done;
  assign granted_c  = (state != IDLE);

  assign o_if_stall  = i_if_req  & ~o_if_done;
  assign o_mem_stall = i_mem_req & ~o_mem_done;

  bus_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (~granted_c),
    .enable (granted_c & ~i_bus_ready),
    .tc_c   (tc_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
      o_if_rdata  <= '0;
      o_mem_rdata <= '0;
      o_if_done   <= 1'b0;
      o_mem_done  <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_if_done  <= 1'b0;
      o_mem_done <= 1'b0;
      o_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_elig_c) begin
            state       <= GRANT_MEM;
            o_bus_req   <= 1'b1;
            o_bus_we    <= i_mem_we;
            o_bus_addr  <= i_mem_addr;
            o_bus_wdata <= i_mem_wdata;
          end else if (if_elig_c) begin
            state       <= GRANT_IF;
            o_bus_req   <= 1'b1;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= i_if_addr;
            o_bus_wdata <= '0;
          end
        end
        GRANT_IF, GRANT_MEM: begin
          // Ready on the terminal cycle still counts as a successful access.
          if (i_bus_ready || tc_c) begin
            state     <= IDLE;
            o_bus_req <= 1'b0;
            o_bus_we  <= 1'b0;
            o_err     <= ~i_bus_ready;
            if (state == GRANT_IF) begin
              o_if_done  <= 1'b1;
              o_if_rdata <= i_bus_ready ? i_bus_rdata : ERR_DATA;
            end else begin
              o_mem_done  <= 1'b1;
              o_mem_rdata <= i_bus_ready ? i_bus_rdata : ERR_DATA;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed corner cases plus randomized two-port
// scenarios compared against a timeline model computed from the arbitration rules.
module tb_memory_arbiter;

  localparam int          T   = 16;
  localparam logic [31:0] ERR = 32'h0000_0000;
  localparam int          NONE = -100;

  logic        clk;
  logic        reset;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic [31:0] o_if_rdata;
  logic        o_if_done;
  logic        o_if_stall;
  logic        i_mem_req;
  logic        i_mem_we;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_wdata;
  logic [31:0] o_mem_rdata;
  logic        o_mem_done;
  logic        o_mem_stall;
  logic        o_err;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;

  int          n_checks;
  int          n_errors;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_mem_rdata;

  memory_arbiter #(
    .TIMEOUT  (T),
    .ERR_DATA (ERR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_rdata  (o_if_rdata),
    .o_if_done   (o_if_done),
    .o_if_stall  (o_if_stall),
    .i_mem_req   (i_mem_req),
    .i_mem_we    (i_mem_we),
    .i_mem_addr  (i_mem_addr),
    .i_mem_wdata (i_mem_wdata),
    .o_mem_rdata (o_mem_rdata),
    .o_mem_done  (o_mem_done),
    .o_mem_stall (o_mem_stall),
    .o_err       (o_err),
    .o_bus_req   (o_bus_req),
    .o_bus_we    (o_bus_we),
    .o_bus_addr  (o_bus_addr),
    .o_bus_wdata (o_bus_wdata),
    .i_bus_ready (i_bus_ready),
    .i_bus_rdata (i_bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grant cycles an access occupies: ready after d waits, or the full timeout.
  function automatic int acc_len(input int d);
    return (d < T) ? d + 1 : T;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".bus_req"},   32'(o_bus_req),   32'd0);
    check({tag, ".bus_we"},    32'(o_bus_we),    32'd0);
    check({tag, ".bus_addr"},  o_bus_addr,       32'd0);
    check({tag, ".bus_wdata"}, o_bus_wdata,      32'd0);
    check({tag, ".if_rdata"},  o_if_rdata,       32'd0);
    check({tag, ".mem_rdata"}, o_mem_rdata,      32'd0);
    check({tag, ".if_done"},   32'(o_if_done),   32'd0);
    check({tag, ".mem_done"},  32'(o_mem_done),  32'd0);
    check({tag, ".err"},       32'(o_err),       32'd0);
  endtask

  // One scenario: both requests (if valid) rise in cycle 0; called at a drive point
  // just after a rising edge and returns at the drive point after the last cycle.
  task automatic scenario(input string tag,
                          input bit m_v, input bit m_we, input logic [31:0] m_addr,
                          input logic [31:0] m_wdata, input int m_d, input logic [31:0] m_rd,
                          input bit f_v, input logic [31:0] f_addr, input int f_d,
                          input logic [31:0] f_rd,
                          output int m_done_obs, output int f_done_obs);
    int m_s, m_e, m_dn, m_rc, f_s, f_e, f_dn, f_rc, last;
    bit m_err, f_err, in_m, in_f, exp_md, exp_fd;
    m_s = NONE; m_e = NONE; m_dn = NONE; m_rc = NONE; m_err = 1'b0;
    f_s = NONE; f_e = NONE; f_dn = NONE; f_rc = NONE; f_err = 1'b0;
    if (m_v) begin
      m_s   = 1;
      m_e   = m_s + acc_len(m_d) - 1;
      m_dn  = m_e + 1;
      m_rc  = (m_d < T) ? m_s + m_d : NONE;
      m_err = (m_d >= T);
    end
    if (f_v) begin
      f_s   = m_v ? m_dn + 1 : 1;
      f_e   = f_s + acc_len(f_d) - 1;
      f_dn  = f_e + 1;
      f_rc  = (f_d < T) ? f_s + f_d : NONE;
      f_err = (f_d >= T);
    end
    last = (m_dn > f_dn) ? m_dn : f_dn;
    m_done_obs = NONE;
    f_done_obs = NONE;
    i_mem_we    = m_we;
    i_mem_addr  = m_addr;
    i_mem_wdata = m_wdata;
    i_if_addr   = f_addr;
    for (int c = 0; c <= last + 1; c++) begin
      i_mem_req = m_v && (c <= m_dn);
      i_if_req  = f_v && (c <= f_dn);
      if (c == m_rc) begin
        i_bus_ready = 1'b1;
        i_bus_rdata = m_rd;
      end else if (c == f_rc) begin
        i_bus_ready = 1'b1;
        i_bus_rdata = f_rd;
      end else begin
        // Stray ready while nothing is granted must be ignored.
        i_bus_ready = (c == 0 || c == m_dn || c == f_dn) ? 1'($urandom_range(0, 1)) : 1'b0;
        i_bus_rdata = $urandom;
      end
      @(negedge clk);
      in_m   = m_v && (c >= m_s) && (c <= m_e);
      in_f   = f_v && (c >= f_s) && (c <= f_e);
      exp_md = m_v && (c == m_dn);
      exp_fd = f_v && (c == f_dn);
      if (exp_md) exp_mem_rdata = m_err ? ERR : m_rd;
      if (exp_fd) exp_if_rdata  = f_err ? ERR : f_rd;
      if (o_mem_done) m_done_obs = c;
      if (o_if_done)  f_done_obs = c;
      check({tag, ".mem_done"},  32'(o_mem_done),  32'(exp_md));
      check({tag, ".if_done"},   32'(o_if_done),   32'(exp_fd));
      check({tag, ".err"},       32'(o_err),       32'((exp_md && m_err) || (exp_fd && f_err)));
      check({tag, ".mem_rdata"}, o_mem_rdata,      exp_mem_rdata);
      check({tag, ".if_rdata"},  o_if_rdata,       exp_if_rdata);
      check({tag, ".mem_stall"}, 32'(o_mem_stall), 32'(i_mem_req && !exp_md));
      check({tag, ".if_stall"},  32'(o_if_stall),  32'(i_if_req && !exp_fd));
      check({tag, ".bus_req"},   32'(o_bus_req),   32'(in_m || in_f));
      if (in_m) begin
        check({tag, ".m_addr"},  o_bus_addr,     m_addr);
        check({tag, ".m_we"},    32'(o_bus_we),  32'(m_we));
        check({tag, ".m_wdata"}, o_bus_wdata,    m_wdata);
      end
      if (in_f) begin
        check({tag, ".f_addr"},  o_bus_addr,     f_addr);
        check({tag, ".f_we"},    32'(o_bus_we),  32'd0);
      end
      @(posedge clk);
      #1;
    end
    i_bus_ready = 1'b0;
  endtask

  initial begin
    int md, fd, d1, d2;
    bit mv, fv, we;
    n_checks      = 0;
    n_errors      = 0;
    exp_if_rdata  = 32'd0;
    exp_mem_rdata = 32'd0;
    reset       = 1'b1;
    i_if_req    = 1'b0;
    i_if_addr   = 32'd0;
    i_mem_req   = 1'b0;
    i_mem_we    = 1'b0;
    i_mem_addr  = 32'd0;
    i_mem_wdata = 32'd0;
    i_bus_ready = 1'b0;
    i_bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Minimal-latency fetch.
    scenario("fetch", 1'b0, 1'b0, 32'd0, 32'd0, 0, 32'd0,
             1'b1, 32'h0000_0040, 0, 32'h2008_0005, md, fd);
    check("fetch.done_cycle", 32'(fd), 32'd2);

    // Simultaneous requests: data store wins, fetch follows.
    scenario("both", 1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 1, 32'h1111_2222,
             1'b1, 32'h0000_0044, 1, 32'h3333_4444, md, fd);
    check("both.spacing", 32'(fd - md), 32'd3);

    // Memory never answers: abort after the full timeout.
    scenario("timeout", 1'b1, 1'b0, 32'h0000_0200, 32'd0, 1000, 32'h5555_6666,
             1'b0, 32'd0, 0, 32'd0, md, fd);
    check("timeout.done_cycle", 32'(md), 32'(T + 1));

    // Ready on the terminal cycle and either side of it.
    scenario("tc_ready", 1'b1, 1'b0, 32'h0000_0204, 32'd0, T - 1, 32'h7777_8888,
             1'b0, 32'd0, 0, 32'd0, md, fd);
    scenario("tc_m1", 1'b0, 1'b0, 32'd0, 32'd0, 0, 32'd0,
             1'b1, 32'h0000_0048, T - 2, 32'h9999_AAAA, md, fd);
    scenario("tc_p1", 1'b0, 1'b0, 32'd0, 32'd0, 0, 32'd0,
             1'b1, 32'h0000_004C, T, 32'hBBBB_CCCC, md, fd);

    // Reset during the second grant cycle of a data access.
    i_mem_req  = 1'b1;
    i_mem_we   = 1'b0;
    i_mem_addr = 32'h0000_0300;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_mid.bus_req_before", 32'(o_bus_req), 32'd1);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    i_mem_req = 1'b0;
    #1;
    check_all_zero("rst_mid");
    check("rst_mid.mem_stall", 32'(o_mem_stall), 32'd0);
    exp_if_rdata  = 32'd0;
    exp_mem_rdata = 32'd0;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_after.mem_done", 32'(o_mem_done), 32'd0);
    check("rst_after.bus_req",  32'(o_bus_req),  32'd0);
    @(posedge clk);
    #1;
    scenario("post_rst", 1'b1, 1'b0, 32'h0000_0304, 32'd0, 0, 32'hDEAD_BEEF,
             1'b0, 32'd0, 0, 32'd0, md, fd);
    check("post_rst.done_cycle", 32'(md), 32'd2);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      mv = 1'($urandom_range(0, 1));
      fv = 1'($urandom_range(0, 1));
      if (!mv && !fv) fv = 1'b1;
      we = 1'($urandom_range(0, 1));
      d1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(T - 2, T + 1)) : int'($urandom_range(0, 3));
      d2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(T - 2, T + 1)) : int'($urandom_range(0, 3));
      scenario("rand", mv, we, $urandom, $urandom, d1, $urandom,
               fv, $urandom, d2, $urandom, md, fd);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
